sram_arbiter: RTL
=================

// Module: sram_arbiter
// PURPOSE
//  Synchronous two-requester front end for the external 32Kx8 asynchronous SRAM.
//  Grants one requester at a time (round-robin) and converts each request into a timed n_cs/n_oe/n_we sequence.
//  Timing meets 55 ns access and the 55 ns post-WE-rise address/data hold.
//  Sits between the CPU memory port (req0) and the loader/debug port (req1) and the SRAM pins.
// PARAMETERS
//  A_WIDTH      15  SRAM address width
//  D_WIDTH      8   SRAM data width
//  RD_CYCLES    6   clk cycles n_oe low before read data is sampled (>=1; 6 covers 55 ns at 10 ns clk)
//  WE_CYCLES    6   clk cycles n_we held low (>=1)
//  HOLD_CYCLES  6   clk cycles a/d/n_cs held after n_we rises (>=1)
// PORTS
//  clk         in   1        clock, all state on posedge
//  rst         in   1        asynchronous reset, active-high
//  req0/req1   in   1        access request; held with addr/we/wdata until matching ack
//  we0/we1     in   1        1 = write, 0 = read
//  addr0/addr1 in   A_WIDTH  word address
//  wdata0/1    in   D_WIDTH  write data
//  ack0/ack1   out  1        one-cycle completion pulse
//  rdata       out  D_WIDTH  read data, shared; valid in the ack cycle and held until the next read completes
//  sram_a      out  A_WIDTH  SRAM address
//  sram_d_out  out  D_WIDTH  SRAM write data
//  sram_d_oe   out  1        drive enable for the top-level tristate on the SRAM d bus
//  sram_d_in   in   D_WIDTH  SRAM d bus sampled value
//  sram_n_cs, sram_n_oe, sram_n_we  out 1  active-low SRAM strobes
// BEHAVIOUR
//  - Reset values: n_cs=n_oe=n_we=1; d_oe=0; ack0=ack1=0; rdata=0; sram_a=0; sram_d_out=0.
//    Also state=IDLE, rr pointer=1, so req0 wins first.
//  - All outputs are registered: no combinational path from req to the SRAM pins.
//  - IDLE: strobes high.
//    - If any req, grant per round-robin: single requester wins; both -> requester != last granted.
//    - Latch addr/we/wdata of the winner, update the pointer, set sram_a.
//    - Go to RD or WR_SETUP.
//  - RD: n_cs=0, n_oe=0 for RD_CYCLES cycles.
//    - Capture sram_d_in into rdata on the last of those cycles.
//    - Then DONE.
//  - WR_SETUP, 1 cycle: n_cs=0, d_oe=1, sram_d_out=wdata, n_we=1.
//  - WR_PULSE, WE_CYCLES cycles: n_we=0.
//  - WR_HOLD, HOLD_CYCLES cycles: n_we=1.
//    - n_cs=0, sram_a and sram_d_out unchanged, d_oe=1 (SRAM latches 55 ns after WE rise).
//    - Then DONE.
//  - DONE, 1 cycle: all strobes high, d_oe=0; ack of the granted requester=1; then IDLE.
//  - Min idle gap: one IDLE cycle always separates accesses (bus turnaround).
//  - Latency, req sampled in IDLE to ack: read RD_CYCLES+1; write 1+WE_CYCLES+HOLD_CYCLES+1 cycles.
//  - A requester keeping req high after its ack issues a new access.
//    - It is arbitrated normally in the next IDLE and cannot starve the other side.
//  - req dropped before ack: access still completes, ack still pulses (no cancel).
//  - Phase counter: $clog2(max cycles)+1 bits, loads count-1 on state entry, advances at 0.
//  - Reset mid-access: strobes go high and d_oe low asynchronously; no ack is issued.
//    - Reset during WR_PULSE/WR_HOLD leaves that SRAM word undefined.
//  - n_oe and n_we are never low together; d_oe=1 only in WR_* states.
// STRUCTURE
//  - Shared include sram_ctrl_defs.vh: state encodings (IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE) and default cycle constants.
//  - Sub-module sram_rr_arbiter: 2-way round-robin.
//    - Inputs: req[1:0], advance, last pointer. Outputs: one-hot grant.
//  - Top level: FSM, phase counter, latched request, pin registers.
// TESTING (bench instantiates async_ram behind a tristate on d, clk 10 ns, defaults)
//  1. Reset held: n_cs/n_oe/n_we=1, d_oe=0, ack=0.
//     Release, no req for 10 cycles -> pins unchanged.
//  2. req0 write addr=0x1234 data=0xA5, then read 0x1234.
//     -> ack0 after 14 / 7 cycles, rdata=0xA5, n_we low exactly 60 ns.
//  3. req0 and req1 both assert writes in the same cycle (0x0001<-0x11, 0x0002<-0x22), held.
//     -> grants 0,1,0,1...; reads back 0x11/0x22; no ack on a non-granted port.
//  4. Pin checker throughout: a/d stable from WR_SETUP to end of WR_HOLD.
//     -> n_cs low across the n_we rising edge; n_oe and n_we never both low; d_oe=0 during RD.
//  5. rst pulsed in 3rd WR_PULSE cycle.
//     -> strobes high within the same time step, no ack, FSM in IDLE.
//     -> next access to another address completes correctly.
//  6. req1 read held continuously while req0 idle.
//     -> back-to-back acks every 8 cycles; req0 then asserts and is granted at the next IDLE.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the async SRAM front end.
// State encoding, default timing constants and a sizing helper.
package sram_arbiter_pkg;

  localparam int A_W_DEF  = 15;
  localparam int D_W_DEF  = 8;
  localparam int RD_DEF   = 6;
  localparam int WE_DEF   = 6;
  localparam int HOLD_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_DONE
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr.sv
// Two-way round-robin grant for the SRAM front end.
// Grants only while advance_i is high; a tie goes to the side not served last.
module sram_arbiter_rr (
  input  logic [1:0] req_i,
  input  logic       advance_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // one-hot grant, tie broken away from the last winner
  always_comb begin
    gnt_o = 2'b00;
    if (advance_i) begin
      unique case (1'b1)
        (req_i == 2'b01): gnt_o = 2'b01;
        (req_i == 2'b10): gnt_o = 2'b10;
        (req_i == 2'b11): gnt_o = last_i ? 2'b01 : 2'b10;
        default:          gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester front end for a 32Kx8 asynchronous SRAM.
// Round-robin grant, timed strobe sequencing, all pins registered.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int A_WIDTH     = A_W_DEF,
  parameter int D_WIDTH     = D_W_DEF,
  parameter int RD_CYCLES   = RD_DEF,
  parameter int WE_CYCLES   = WE_DEF,
  parameter int HOLD_CYCLES = HOLD_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req0_i,
  input  logic               req1_i,
  input  logic               we0_i,
  input  logic               we1_i,
  input  logic [A_WIDTH-1:0] addr0_i,
  input  logic [A_WIDTH-1:0] addr1_i,
  input  logic [D_WIDTH-1:0] wdata0_i,
  input  logic [D_WIDTH-1:0] wdata1_i,
  output logic               ack0_o,
  output logic               ack1_o,
  output logic [D_WIDTH-1:0] rdata_o,
  output logic [A_WIDTH-1:0] sram_a_o,
  output logic [D_WIDTH-1:0] sram_d_out_o,
  output logic               sram_d_oe_o,
  input  logic [D_WIDTH-1:0] sram_d_in_i,
  output logic               sram_n_cs_o,
  output logic               sram_n_oe_o,
  output logic               sram_n_we_o
);

  localparam int MAXC  = max3(RD_CYCLES, WE_CYCLES, HOLD_CYCLES);
  localparam int CNT_W = $clog2(MAXC) + 1;

  localparam logic [CNT_W-1:0] RD_LD   = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WE_LD   = CNT_W'(WE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ptr_q, ptr_d;
  logic [1:0]         gnt;
  logic               win_we;
  logic [A_WIDTH-1:0] win_addr;
  logic [D_WIDTH-1:0] win_wdata;
  logic               cnt_zero;

  logic               ack0_q, ack1_q;
  logic [D_WIDTH-1:0] rdata_q;
  logic [A_WIDTH-1:0] a_q;
  logic [D_WIDTH-1:0] dout_q;
  logic               doe_q, n_cs_q, n_oe_q, n_we_q;

  sram_arbiter_rr u_rr (
    .req_i     ({req1_i, req0_i}),
    .advance_i (state_q == ST_IDLE),
    .last_i    (ptr_q),
    .gnt_o     (gnt)
  );

  assign win_we    = gnt[1] ? we1_i    : we0_i;
  assign win_addr  = gnt[1] ? addr1_i  : addr0_i;
  assign win_wdata = gnt[1] ? wdata1_i : wdata0_i;
  assign cnt_zero  = (cnt_q == '0);

  // next state, phase counter and round-robin pointer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          ptr_d   = gnt[1];
          state_d = win_we ? ST_WR_SETUP : ST_RD;
          cnt_d   = win_we ? '0 : RD_LD;
        end
      end
      ST_RD: begin
        if (cnt_zero) state_d = ST_DONE;
        else          cnt_d   = cnt_q - 1'b1;
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        cnt_d   = WE_LD;
      end
      ST_WR_PULSE: begin
        if (cnt_zero) begin
          state_d = ST_WR_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WR_HOLD: begin
        if (cnt_zero) state_d = ST_DONE;
        else          cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state, counter and pointer registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // pin registers follow the state being entered so strobes align with it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      n_cs_q  <= 1'b1;
      n_oe_q  <= 1'b1;
      n_we_q  <= 1'b1;
      doe_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= '0;
      a_q     <= '0;
      dout_q  <= '0;
    end else begin
      n_cs_q <= (state_d == ST_IDLE) || (state_d == ST_DONE);
      n_oe_q <= (state_d != ST_RD);
      n_we_q <= (state_d != ST_WR_PULSE);
      doe_q  <= (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE)
             || (state_d == ST_WR_HOLD);
      ack0_q <= (state_d == ST_DONE) && !ptr_q;
      ack1_q <= (state_d == ST_DONE) && ptr_q;
      if ((state_q == ST_IDLE) && (|gnt)) begin
        a_q <= win_addr;
        if (win_we) dout_q <= win_wdata;
      end
      if ((state_q == ST_RD) && cnt_zero) rdata_q <= sram_d_in_i;
    end
  end

  assign ack0_o       = ack0_q;
  assign ack1_o       = ack1_q;
  assign rdata_o      = rdata_q;
  assign sram_a_o     = a_q;
  assign sram_d_out_o = dout_q;
  assign sram_d_oe_o  = doe_q;
  assign sram_n_cs_o  = n_cs_q;
  assign sram_n_oe_o  = n_oe_q;
  assign sram_n_we_o  = n_we_q;

endmodule
